// File: rtl/washer_pkg.sv
// ============================================================================
// Module      : washer_pkg
// Description : Shared FSM states, coin encodings and default prices for the
//               washer coin acceptor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package washer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_START   = 2'd2,
        ST_RUN     = 2'd3
    } state_t;

    localparam logic [1:0] c_COIN_1  = 2'b00;
    localparam logic [1:0] c_COIN_2  = 2'b01;
    localparam logic [1:0] c_COIN_5  = 2'b10;
    localparam logic [1:0] c_COIN_10 = 2'b11;

    // Widest denomination (10 units) fits in four bits.
    localparam int c_UNIT_W = 4;

    localparam int c_PRICE_SINGLE_DEF = 10;
    localparam int c_PRICE_DOUBLE_DEF = 15;
    localparam int c_CREDIT_W_DEF     = 6;

endpackage

`default_nettype wire

// File: rtl/coin_acceptor_if.sv
// ============================================================================
// Module      : coin_acceptor_if
// Description : Coin, selection and wash-FSM handshake bundle for the acceptor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface coin_acceptor_if
    import washer_pkg::*;
#(
    parameter int CREDIT_W = c_CREDIT_W_DEF
) ();

    logic                coin_valid;
    logic [1:0]          coin_value;
    logic                double_wash_sel;
    logic                refund_req;
    logic                laundry_done;
    logic                coin_insert;
    logic                double_wash;
    logic [CREDIT_W-1:0] credit;
    logic                change_valid;
    logic [CREDIT_W-1:0] change_amount;
    logic                coin_reject;

    modport master (
        output coin_valid, coin_value, double_wash_sel, refund_req, laundry_done,
        input  coin_insert, double_wash, credit, change_valid, change_amount, coin_reject
    );

    modport slave (
        input  coin_valid, coin_value, double_wash_sel, refund_req, laundry_done,
        output coin_insert, double_wash, credit, change_valid, change_amount, coin_reject
    );

endinterface

`default_nettype wire

// File: rtl/coin_decoder.sv
// ============================================================================
// Module      : coin_decoder
// Description : Combinational map from coin denomination code to credit units.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module coin_decoder
    import washer_pkg::*;
(
    input  wire [1:0]           i_coin_value,
    output logic [c_UNIT_W-1:0] o_units
);

    always_comb begin
        o_units = '0;
        case (i_coin_value)
            c_COIN_1:  o_units = c_UNIT_W'(1);
            c_COIN_2:  o_units = c_UNIT_W'(2);
            c_COIN_5:  o_units = c_UNIT_W'(5);
            c_COIN_10: o_units = c_UNIT_W'(10);
            default:   o_units = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/coin_acceptor.sv
// ============================================================================
// Module      : coin_acceptor
// Description : Accumulates coin credit, starts a single/double wash once the
//               price is met and returns change. Optional refund path is
//               enabled by defining macro COIN_REFUND_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module coin_acceptor
    import washer_pkg::*;
#(
    parameter int PRICE_SINGLE = c_PRICE_SINGLE_DEF,
    parameter int PRICE_DOUBLE = c_PRICE_DOUBLE_DEF,
    parameter int CREDIT_W     = c_CREDIT_W_DEF
) (
    input  wire             clk,
    input  wire             rst,
    coin_acceptor_if.slave  bus
);

    localparam logic [31:0] c_CREDIT_MAX = 32'((64'd1 << CREDIT_W) - 64'd1);

    state_t              r_state;
    logic [CREDIT_W-1:0] r_credit;
    logic [CREDIT_W-1:0] r_change_amount;
    logic                r_coin_insert;
    logic                r_double_wash;
    logic                r_change_valid;
    logic                r_coin_reject;

    logic [c_UNIT_W-1:0] w_units;
    logic [31:0]         w_sum;
    logic [31:0]         w_price;
    logic                w_overflow;
    logic                w_meets_price;
    logic                w_refund;

    coin_decoder u_coin_decoder (
        .i_coin_value (bus.coin_value),
        .o_units      (w_units)
    );

    // Sum is formed wide so an overflowing coin can be detected and refused.
    assign w_sum         = 32'(r_credit) + 32'(w_units);
    assign w_price       = bus.double_wash_sel ? 32'(PRICE_DOUBLE) : 32'(PRICE_SINGLE);
    assign w_overflow    = (w_sum > c_CREDIT_MAX);
    assign w_meets_price = (w_sum >= w_price);

`ifdef COIN_REFUND_EN
    assign w_refund = bus.refund_req;
`else
    logic w_unused_refund;
    assign w_unused_refund = bus.refund_req;
    assign w_refund        = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state         <= ST_IDLE;
            r_credit        <= '0;
            r_change_amount <= '0;
            r_coin_insert   <= 1'b0;
            r_double_wash   <= 1'b0;
            r_change_valid  <= 1'b0;
            r_coin_reject   <= 1'b0;
        end else begin
            r_coin_insert  <= 1'b0;
            r_change_valid <= 1'b0;
            r_coin_reject  <= 1'b0;
            case (r_state)
                ST_IDLE, ST_COLLECT: begin
                    if ((r_state == ST_COLLECT) && w_refund) begin
                        // Refund wins over a coin arriving in the same cycle.
                        r_change_amount <= r_credit;
                        r_change_valid  <= 1'b1;
                        r_credit        <= '0;
                        r_coin_reject   <= bus.coin_valid;
                        r_state         <= ST_IDLE;
                    end else if (bus.coin_valid) begin
                        if (w_overflow) begin
                            r_coin_reject <= 1'b1;
                        end else if (w_meets_price) begin
                            r_credit        <= CREDIT_W'(w_sum);
                            r_change_amount <= CREDIT_W'(w_sum - w_price);
                            r_change_valid  <= 1'b1;
                            r_coin_insert   <= 1'b1;
                            r_double_wash   <= bus.double_wash_sel;
                            r_state         <= ST_START;
                        end else begin
                            r_credit <= CREDIT_W'(w_sum);
                            r_state  <= ST_COLLECT;
                        end
                    end
                end
                ST_START: begin
                    r_credit      <= '0;
                    r_coin_reject <= bus.coin_valid;
                    r_state       <= ST_RUN;
                end
                ST_RUN: begin
                    r_coin_reject <= bus.coin_valid;
                    if (bus.laundry_done) begin
                        r_double_wash <= 1'b0;
                        r_state       <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.coin_insert   = r_coin_insert;
    assign bus.double_wash   = r_double_wash;
    assign bus.credit        = r_credit;
    assign bus.change_valid  = r_change_valid;
    assign bus.change_amount = r_change_amount;
    assign bus.coin_reject   = r_coin_reject;

endmodule

`default_nettype wire

// File: tb/tb_coin_acceptor.sv
// ============================================================================
// Module      : tb_coin_acceptor
// Description : Scoreboard bench for coin_acceptor with a behavioural credit
//               model; honours COIN_REFUND_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_coin_acceptor;
    import washer_pkg::*;

    localparam int PS   = 10;
    localparam int PD   = 15;
    localparam int CW   = 6;
    localparam int MAXC = (1 << CW) - 1;
    localparam int K_START  = 0;
    localparam int K_REFUND = 1;
    localparam int K_REJECT = 2;
`ifdef COIN_REFUND_EN
    localparam bit REFUND_EN = 1'b1;
`else
    localparam bit REFUND_EN = 1'b0;
`endif

    typedef struct { int tag; int credit; bit dw; } cr_t;
    typedef struct { int tag; int kind; int amount; bit dw; } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_err = 0;

    cr_t q_cr[$];
    ev_t q_ev[$];
    cr_t mon_cr;
    ev_t mon_ev;

    int m_credit = 0;
    bit m_dw = 1'b0;
    bit m_starting = 1'b0;
    bit m_running = 1'b0;

    coin_acceptor_if #(.CREDIT_W(CW)) ifa ();
    coin_acceptor_if #(.CREDIT_W(4))  ifb ();

    coin_acceptor #(.PRICE_SINGLE(PS), .PRICE_DOUBLE(PD), .CREDIT_W(CW)) dut_a (
        .clk (clk), .rst (rst), .bus (ifa)
    );
    coin_acceptor #(.PRICE_SINGLE(20), .PRICE_DOUBLE(20), .CREDIT_W(4)) dut_b (
        .clk (clk), .rst (rst), .bus (ifb)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int denom(input logic [1:0] v);
        case (v)
            2'b00:   return 1;
            2'b01:   return 2;
            2'b10:   return 5;
            default: return 10;
        endcase
    endfunction

    // Behavioural model: credit bookkeeping plus a busy window (one start
    // cycle, then running until laundry_done).
    task automatic model_step(input bit cv, input logic [1:0] val, input bit sel,
                              input bit rr, input bit ld);
        int  sum;
        int  price;
        ev_t ev;
        cr_t cr;
        sum       = m_credit + denom(val);
        price     = sel ? PD : PS;
        ev.tag    = cyc + 1;
        ev.kind   = K_REJECT;
        ev.amount = 0;
        ev.dw     = 1'b0;
        if (m_starting) begin
            if (cv) q_ev.push_back(ev);
            m_credit   = 0;
            m_starting = 1'b0;
            m_running  = 1'b1;
        end else if (m_running) begin
            if (cv) q_ev.push_back(ev);
            if (ld) begin
                m_running = 1'b0;
                m_dw      = 1'b0;
            end
        end else if (REFUND_EN && rr && (m_credit != 0)) begin
            ev.kind   = K_REFUND;
            ev.amount = m_credit;
            q_ev.push_back(ev);
            if (cv) begin
                ev.kind   = K_REJECT;
                ev.amount = 0;
                q_ev.push_back(ev);
            end
            m_credit = 0;
        end else if (cv) begin
            if (sum > MAXC) begin
                q_ev.push_back(ev);
            end else if (sum >= price) begin
                ev.kind    = K_START;
                ev.amount  = sum - price;
                ev.dw      = sel;
                q_ev.push_back(ev);
                m_credit   = sum;
                m_dw       = sel;
                m_starting = 1'b1;
            end else begin
                m_credit = sum;
            end
        end
        cr.tag    = cyc + 1;
        cr.credit = m_credit;
        cr.dw     = m_dw;
        q_cr.push_back(cr);
    endtask

    task automatic model_reset();
        m_credit   = 0;
        m_dw       = 1'b0;
        m_starting = 1'b0;
        m_running  = 1'b0;
        q_cr.delete();
        q_ev.delete();
    endtask

    task automatic drive(input bit cv, input logic [1:0] val, input bit sel,
                         input bit rr, input bit ld);
        ifa.coin_valid      = cv;
        ifa.coin_value      = val;
        ifa.double_wash_sel = sel;
        ifa.refund_req      = rr;
        ifa.laundry_done    = ld;
        model_step(cv, val, sel, rr, ld);
        @(posedge clk);
        #1;
    endtask

    // Monitor: per-cycle credit/double_wash, plus every output pulse.
    always @(negedge clk) begin
        if (rst) begin
            if (q_cr.size() != 0 && q_cr[0].tag == cyc) begin
                mon_cr = q_cr.pop_front();
                check("credit", int'(ifa.credit), mon_cr.credit);
                check("double_wash", int'(ifa.double_wash), int'(mon_cr.dw));
            end
            if (ifa.coin_insert || ifa.change_valid) begin
                if (q_ev.size() != 0 && q_ev[0].tag == cyc) begin
                    mon_ev = q_ev.pop_front();
                    check("change_event_kind", ifa.coin_insert ? K_START : K_REFUND, mon_ev.kind);
                    check("change_valid", int'(ifa.change_valid), 1);
                    check("change_amount", int'(ifa.change_amount), mon_ev.amount);
                    if (ifa.coin_insert) check("double_wash_at_start", int'(ifa.double_wash), int'(mon_ev.dw));
                end else begin
                    n_checks++;
                    n_err++;
                    $display("FAIL unexpected_change: coin_insert=%0d change_valid=%0d amount=%0d, none expected (cycle %0d)",
                             ifa.coin_insert, ifa.change_valid, ifa.change_amount, cyc);
                end
            end
            if (ifa.coin_reject) begin
                if (q_ev.size() != 0 && q_ev[0].tag == cyc) begin
                    mon_ev = q_ev.pop_front();
                    check("reject_event_kind", K_REJECT, mon_ev.kind);
                end else begin
                    n_checks++;
                    n_err++;
                    $display("FAIL unexpected_reject: coin_reject=1, none expected (cycle %0d)", cyc);
                end
            end
            while (q_ev.size() != 0 && q_ev[0].tag <= cyc) begin
                mon_ev = q_ev.pop_front();
                n_checks++;
                n_err++;
                $display("FAIL missing_event: kind=%0d amount=%0d expected at cycle %0d, not seen",
                         mon_ev.kind, mon_ev.amount, mon_ev.tag);
            end
        end
    end

    initial begin
        ifa.coin_valid = 1'b0; ifa.coin_value = 2'b00; ifa.double_wash_sel = 1'b0;
        ifa.refund_req = 1'b0; ifa.laundry_done = 1'b0;
        ifb.coin_valid = 1'b0; ifb.coin_value = 2'b00; ifb.double_wash_sel = 1'b0;
        ifb.refund_req = 1'b0; ifb.laundry_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_credit", int'(ifa.credit), 0);
        check("reset_coin_insert", int'(ifa.coin_insert), 0);
        check("reset_change_valid", int'(ifa.change_valid), 0);
        rst = 1'b1;

        // Single wash: 5 + 5 at sel=0, no change.
        drive(1, 2'b10, 0, 0, 0);
        drive(1, 2'b10, 0, 0, 0);
        drive(0, 2'b00, 0, 0, 0);
        drive(0, 2'b00, 0, 0, 1);
        // Double wash: 10 + 10 at sel=1, change 5; then a coin while running.
        drive(1, 2'b11, 1, 0, 0);
        drive(1, 2'b11, 1, 0, 0);
        drive(0, 2'b00, 1, 0, 0);
        drive(1, 2'b01, 0, 0, 0);
        drive(0, 2'b00, 0, 0, 1);
        drive(0, 2'b00, 0, 0, 0);
        // Coins 2, 2 then refund; then two tens at sel=1 to finish a cycle.
        drive(1, 2'b01, 0, 0, 0);
        drive(1, 2'b01, 0, 0, 0);
        drive(0, 2'b00, 0, 1, 0);
        drive(0, 2'b00, 0, 0, 0);
        drive(1, 2'b11, 1, 0, 0);
        drive(1, 2'b11, 1, 0, 0);
        drive(0, 2'b00, 0, 0, 0);
        drive(0, 2'b00, 0, 0, 1);

        // Saturation on the narrow instance: 10, 5, then 2 overflows 15.
        ifb.coin_valid = 1'b1;
        ifb.coin_value = 2'b11;
        drive(0, 2'b00, 0, 0, 0);
        ifb.coin_value = 2'b10;
        drive(0, 2'b00, 0, 0, 0);
        check("sat_credit_after_15", int'(ifb.credit), 15);
        check("sat_no_start", int'(ifb.coin_insert), 0);
        ifb.coin_value = 2'b01;
        drive(0, 2'b00, 0, 0, 0);
        check("sat_reject", int'(ifb.coin_reject), 1);
        check("sat_credit_held", int'(ifb.credit), 15);
        ifb.coin_valid = 1'b0;
        drive(0, 2'b00, 0, 0, 0);
        check("sat_reject_one_cycle", int'(ifb.coin_reject), 0);
        check("sat_credit_still_15", int'(ifb.credit), 15);

        // Reset while collecting with credit 7.
        drive(1, 2'b10, 0, 0, 0);
        drive(1, 2'b01, 0, 0, 0);
        @(negedge clk);
        #1;
        ifa.coin_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("rst_credit", int'(ifa.credit), 0);
        check("rst_coin_insert", int'(ifa.coin_insert), 0);
        check("rst_double_wash", int'(ifa.double_wash), 0);
        check("rst_change_valid", int'(ifa.change_valid), 0);
        check("rst_change_amount", int'(ifa.change_amount), 0);
        check("rst_coin_reject", int'(ifa.coin_reject), 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;

        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 99) < 45, 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), $urandom_range(0, 99) < 10,
                  $urandom_range(0, 99) < 25);
        end
        repeat (4) drive(0, 2'b00, 0, 0, 0);
        @(negedge clk);
        #1;
        check("events_outstanding", q_ev.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
